reg_file_bank: RTL and testbench

- 32 x 32-bit architectural register file for the 5-stage pipeline.
- Responder side of the decode/writeback register interface: decode supplies two read addresses, writeback supplies one write address, data and enable.
- Reads are combinational so decode gets operands in the same cycle. Writes commit on the rising clock edge.
- Adds a registered debug read port and a registered $r30-nonzero status flag for the bex/exception path.

---
 rtl/reg_file_bank.sv | 63 ++++++
 tb/tb_reg_file_bank.sv | 162 ++++++++++++++++
 2 files changed

// File: rtl/reg_file_bank.sv
// reg_file_bank: 32x32 register file with combinational A/B reads, registered debug port and r30-nonzero flag.
// Optional REGFILE_BYPASS_EN adds write-through forwarding onto read ports A and B.
module reg_file_bank #(
    parameter int NUM_REGS = 32,
    parameter int DATA_W   = 32,
    parameter int EXC_REG  = 30
) (
    input  logic              clock,
    input  logic              ctrl_reset,
    input  logic              ctrl_writeEnable,
    input  logic [4:0]        ctrl_writeReg,
    input  logic [DATA_W-1:0] data_writeReg,
    input  logic [4:0]        ctrl_readRegA,
    input  logic [4:0]        ctrl_readRegB,
    output logic [DATA_W-1:0] data_readRegA,
    output logic [DATA_W-1:0] data_readRegB,
    input  logic [4:0]        dbg_readReg,
    output logic [DATA_W-1:0] dbg_data,
    output logic              reg30_nonzero,
    output logic [15:0]       write_count
);
    logic [DATA_W-1:0] regs_q [NUM_REGS];
    logic [DATA_W-1:0] dbg_q;
    logic              flag_q, flag_d;
    logic [15:0]       cnt_q, cnt_d;
    logic              wr;
    logic [DATA_W-1:0] stored_a, stored_b;

    assign wr = ctrl_writeEnable && ctrl_writeReg != 5'd0;

    always_comb begin
        stored_a = ctrl_readRegA == 5'd0 ? '0 : regs_q[ctrl_readRegA];
        stored_b = ctrl_readRegB == 5'd0 ? '0 : regs_q[ctrl_readRegB];
        cnt_d    = cnt_q + 16'(wr);
        // flag tracks the post-write value, so a same-edge write to the status register wins
        flag_d   = (wr && ctrl_writeReg == 5'(EXC_REG)) ? |data_writeReg : |regs_q[EXC_REG];
`ifdef REGFILE_BYPASS_EN
        data_readRegA = (wr && !ctrl_reset && ctrl_readRegA == ctrl_writeReg) ? data_writeReg : stored_a;
        data_readRegB = (wr && !ctrl_reset && ctrl_readRegB == ctrl_writeReg) ? data_writeReg : stored_b;
`else
        data_readRegA = stored_a;
        data_readRegB = stored_b;
`endif
    end

    always_ff @(posedge clock) begin
        if (ctrl_reset) begin
            for (int i = 0; i < NUM_REGS; i++) regs_q[i] <= '0;
            dbg_q  <= '0;
            flag_q <= 1'b0;
            cnt_q  <= '0;
        end else begin
            if (wr) regs_q[ctrl_writeReg] <= data_writeReg;
            dbg_q  <= dbg_readReg == 5'd0 ? '0 : regs_q[dbg_readReg];
            flag_q <= flag_d;
            cnt_q  <= cnt_d;
        end
    end

    assign dbg_data      = dbg_q;
    assign reg30_nonzero = flag_q;
    assign write_count   = cnt_q;
endmodule

// File: tb/tb_reg_file_bank.sv
// tb_reg_file_bank: table-driven write/read vectors plus directed hazard, status, reset and wrap sequences.
module tb_reg_file_bank;
    logic        clock = 1'b0;
    logic        ctrl_reset, ctrl_writeEnable;
    logic [4:0]  ctrl_writeReg, ctrl_readRegA, ctrl_readRegB, dbg_readReg;
    logic [31:0] data_writeReg, data_readRegA, data_readRegB, dbg_data;
    logic        reg30_nonzero;
    logic [15:0] write_count;
    int          n_tests = 0, n_fail = 0;

    reg_file_bank dut (
        .clock(clock), .ctrl_reset(ctrl_reset), .ctrl_writeEnable(ctrl_writeEnable),
        .ctrl_writeReg(ctrl_writeReg), .data_writeReg(data_writeReg),
        .ctrl_readRegA(ctrl_readRegA), .ctrl_readRegB(ctrl_readRegB),
        .data_readRegA(data_readRegA), .data_readRegB(data_readRegB),
        .dbg_readReg(dbg_readReg), .dbg_data(dbg_data),
        .reg30_nonzero(reg30_nonzero), .write_count(write_count)
    );

    always #5 clock = ~clock;

    typedef struct {
        logic        we;
        logic [4:0]  wa;
        logic [31:0] wd;
        logic [4:0]  ra, rb;
        logic [31:0] ea, eb;
        logic [15:0] ecnt;
    } vec_t;

    vec_t vecs [10];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic wr(input logic [4:0] a, input logic [31:0] d);
        ctrl_writeEnable = 1'b1;
        ctrl_writeReg    = a;
        data_writeReg    = d;
        tick();
        ctrl_writeEnable = 1'b0;
    endtask

    initial begin
        vecs[0] = '{1'b1, 5'd5,  32'hDEADBEEF, 5'd5,  5'd17, 32'h0,        32'h0,        16'd1};
        vecs[1] = '{1'b1, 5'd17, 32'h12345678, 5'd5,  5'd0,  32'hDEADBEEF, 32'h0,        16'd2};
        vecs[2] = '{1'b0, 5'd0,  32'h0,        5'd5,  5'd17, 32'hDEADBEEF, 32'h12345678, 16'd2};
        vecs[3] = '{1'b1, 5'd0,  32'hFFFFFFFF, 5'd0,  5'd0,  32'h0,        32'h0,        16'd2};
        vecs[4] = '{1'b0, 5'd0,  32'h0,        5'd0,  5'd5,  32'h0,        32'hDEADBEEF, 16'd2};
        vecs[5] = '{1'b1, 5'd9,  32'h11111111, 5'd17, 5'd17, 32'h12345678, 32'h12345678, 16'd3};
        vecs[6] = '{1'b1, 5'd31, 32'hCAFEF00D, 5'd9,  5'd5,  32'h11111111, 32'hDEADBEEF, 16'd4};
        vecs[7] = '{1'b0, 5'd0,  32'h0,        5'd31, 5'd9,  32'hCAFEF00D, 32'h11111111, 16'd4};
        vecs[8] = '{1'b1, 5'd5,  32'h0,        5'd31, 5'd31, 32'hCAFEF00D, 32'hCAFEF00D, 16'd5};
        vecs[9] = '{1'b0, 5'd0,  32'h0,        5'd5,  5'd17, 32'h0,        32'h12345678, 16'd5};

        ctrl_reset = 1'b1; ctrl_writeEnable = 1'b0; ctrl_writeReg = '0; data_writeReg = '0;
        ctrl_readRegA = '0; ctrl_readRegB = '0; dbg_readReg = '0;
        tick();
        ctrl_reset = 1'b0;
        for (int i = 0; i < 32; i++) begin
            ctrl_readRegA = 5'(i);
            ctrl_readRegB = 5'(31 - i);
            #1;
            check($sformatf("reset_a[%0d]", i), data_readRegA, 32'h0);
            check($sformatf("reset_b[%0d]", 31 - i), data_readRegB, 32'h0);
        end
        check("reset_flag", {31'b0, reg30_nonzero}, 32'h0);
        check("reset_cnt", {16'b0, write_count}, 32'h0);
        check("reset_dbg", dbg_data, 32'h0);

        for (int i = 0; i < 10; i++) begin
            ctrl_writeEnable = vecs[i].we;
            ctrl_writeReg    = vecs[i].wa;
            data_writeReg    = vecs[i].wd;
            ctrl_readRegA    = vecs[i].ra;
            ctrl_readRegB    = vecs[i].rb;
            #1;
            check($sformatf("vec%0d_a", i), data_readRegA, vecs[i].ea);
            check($sformatf("vec%0d_b", i), data_readRegB, vecs[i].eb);
            tick();
            check($sformatf("vec%0d_cnt", i), {16'b0, write_count}, {16'b0, vecs[i].ecnt});
        end
        ctrl_writeEnable = 1'b0;

        // same-cycle write/read hazard on r9 (old value 0x11111111)
        ctrl_readRegA = 5'd9; ctrl_readRegB = 5'd9;
        ctrl_writeEnable = 1'b1; ctrl_writeReg = 5'd9; data_writeReg = 32'hA5A5A5A5;
        #1;
`ifdef REGFILE_BYPASS_EN
        check("hazard_a_pre", data_readRegA, 32'hA5A5A5A5);
        check("hazard_b_pre", data_readRegB, 32'hA5A5A5A5);
`else
        check("hazard_a_pre", data_readRegA, 32'h11111111);
        check("hazard_b_pre", data_readRegB, 32'h11111111);
`endif
        tick();
        ctrl_writeEnable = 1'b0;
        check("hazard_a_post", data_readRegA, 32'hA5A5A5A5);
        check("hazard_cnt", {16'b0, write_count}, 32'd6);

        dbg_readReg = 5'd30;
        ctrl_writeEnable = 1'b1; ctrl_writeReg = 5'd30; data_writeReg = 32'h3;
        #1;
        check("flag_pre", {31'b0, reg30_nonzero}, 32'h0);
        tick();
        ctrl_writeEnable = 1'b0;
        check("flag_set", {31'b0, reg30_nonzero}, 32'h1);
        check("dbg_preedge", dbg_data, 32'h0);
        tick();
        check("dbg_r30", dbg_data, 32'h3);
        check("flag_hold", {31'b0, reg30_nonzero}, 32'h1);
        wr(5'd30, 32'h0);
        check("flag_clr", {31'b0, reg30_nonzero}, 32'h0);
        check("dbg_stale", dbg_data, 32'h3);
        dbg_readReg = 5'd31;
        tick();
        check("dbg_r31", dbg_data, 32'hCAFEF00D);
        dbg_readReg = 5'd0;
        tick();
        check("dbg_r0", dbg_data, 32'h0);
        check("cnt_status", {16'b0, write_count}, 32'd8);

        // reset wins over a simultaneous write
        ctrl_reset = 1'b1;
        ctrl_writeEnable = 1'b1; ctrl_writeReg = 5'd4; data_writeReg = 32'h1;
        ctrl_readRegA = 5'd4; ctrl_readRegB = 5'd31;
        tick();
        ctrl_reset = 1'b0; ctrl_writeEnable = 1'b0;
        #1;
        check("rstpri_r4", data_readRegA, 32'h0);
        check("rstpri_r31", data_readRegB, 32'h0);
        check("rstpri_cnt", {16'b0, write_count}, 32'h0);

        ctrl_readRegA = 5'd1;
        ctrl_writeEnable = 1'b1; ctrl_writeReg = 5'd1;
        for (int i = 1; i <= 65535; i++) begin
            data_writeReg = 32'(i);
            tick();
        end
        ctrl_writeEnable = 1'b0;
        check("wrap_ffff", {16'b0, write_count}, 32'h0000FFFF);
        check("wrap_r1", data_readRegA, 32'd65535);
        wr(5'd1, 32'h77);
        check("wrap_zero", {16'b0, write_count}, 32'h0);
        check("wrap_r1_last", data_readRegA, 32'h77);
        wr(5'd0, 32'h5);
        check("r0_nocount", {16'b0, write_count}, 32'h0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
